decoder_select_sequencer: RTL and testbench

//  Drives the 2-bit select pair (Sel1, Sel0) into the 2-to-4 decoder stage directly downstream.

---
 rtl/decoder_select_sequencer.sv | 103 ++++++++++
 tb/tb_decoder_select_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_select_sequencer.sv
// Steps a 2-bit decoder select through P0..P3, free-running at DIV or one position per handshake.
// Optional SEQ_MASK_EN adds Mask[3:0] to skip marked positions.
module decoder_select_sequencer #(
   parameter int DIV   = 4,
   parameter int DIV_W = 8
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Run,
   input  logic       Dir,
   input  logic       Clear,
   input  logic       StepReq,
`ifdef SEQ_MASK_EN
   input  logic [3:0] Mask,
`endif
   output logic       StepAck,
   output logic       Sel1,
   output logic       Sel0,
   output logic       Tick,
   output logic       Wrap
);

   typedef enum logic [1:0] {P0 = 2'd0, P1 = 2'd1, P2 = 2'd2, P3 = 2'd3} pos_t;

   localparam logic [DIV_W-1:0] LP_TC = DIV_W'(DIV - 1);

   pos_t             r_pos;
   logic [DIV_W-1:0] r_presc;
   logic             r_tick, r_wrap, r_ack;
   // Set by reset: a request still high from before reset must drop before it counts.
   logic             r_blk;

   pos_t w_nxt;
   logic w_nxt_wrap, w_can_move, w_fr_adv, w_st_adv;

`ifdef SEQ_MASK_EN
   always_comb begin
      logic [2:0] v_t;
      v_t        = '0;
      w_nxt      = r_pos;
      w_nxt_wrap = 1'b0;
      w_can_move = 1'b0;
      // Scan farthest-first so the nearest unmasked candidate wins.
      for (int k = 4; k >= 1; k--) begin
         v_t = Dir ? ({1'b0, r_pos} - 3'(k)) : ({1'b0, r_pos} + 3'(k));
         if (!Mask[v_t[1:0]]) begin
            w_can_move = 1'b1;
            w_nxt      = pos_t'(v_t[1:0]);
            w_nxt_wrap = v_t[2];
         end
      end
   end
`else
   always_comb begin
      w_can_move = 1'b1;
      w_nxt      = Dir ? pos_t'(r_pos - 2'd1) : pos_t'(r_pos + 2'd1);
      w_nxt_wrap = Dir ? (r_pos == P0) : (r_pos == P3);
   end
`endif

   assign w_fr_adv = Run && (r_presc == LP_TC);
   assign w_st_adv = !Run && StepReq && !r_ack && !r_blk;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_pos   <= P0;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
         r_ack   <= 1'b0;
         r_blk   <= 1'b1;
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         if (!StepReq) begin
            r_ack <= 1'b0;
            r_blk <= 1'b0;
         end
         if (Clear) begin
            r_pos   <= P0;
            r_presc <= '0;
         end else begin
            if (Run)
               r_presc <= (r_presc == LP_TC) ? '0 : r_presc + 1'b1;
            if (w_fr_adv || w_st_adv) begin
               if (w_can_move)
                  r_pos <= w_nxt;
               r_tick <= w_can_move;
               r_wrap <= w_can_move && w_nxt_wrap;
            end
            if (w_st_adv)
               r_ack <= 1'b1;
         end
      end
   end

   assign Sel1    = r_pos[1];
   assign Sel0    = r_pos[0];
   assign Tick    = r_tick;
   assign Wrap    = r_wrap;
   assign StepAck = r_ack;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed bench for decoder_select_sequencer (DIV=4); define SEQ_MASK_EN to add the mask steps.
module tb_decoder_select_sequencer;

   logic Clk = 1'b0;
   logic Rst_n, Run, Dir, Clear, StepReq;
   logic StepAck, Sel1, Sel0, Tick, Wrap;
`ifdef SEQ_MASK_EN
   logic [3:0] Mask;
`endif
   int n_vec = 0;
   int n_err = 0;

   decoder_select_sequencer #(.DIV(4), .DIV_W(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Dir(Dir), .Clear(Clear), .StepReq(StepReq),
`ifdef SEQ_MASK_EN
      .Mask(Mask),
`endif
      .StepAck(StepAck), .Sel1(Sel1), .Sel0(Sel0), .Tick(Tick), .Wrap(Wrap)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1ns so checks and new drives sit away from the edge.
   task automatic clk1();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [1:0] sel, input logic t, input logic w,
                          input logic a);
      chk({tag, ".sel"}, {6'd0, Sel1, Sel0}, {6'd0, sel});
      chk({tag, ".tick"}, {7'd0, Tick}, {7'd0, t});
      chk({tag, ".wrap"}, {7'd0, Wrap}, {7'd0, w});
      chk({tag, ".ack"}, {7'd0, StepAck}, {7'd0, a});
   endtask

   logic [1:0] up_seq [4];

   initial begin
      up_seq = '{2'b01, 2'b10, 2'b11, 2'b00};
      Rst_n = 1'b0; Run = 1'b0; Dir = 1'b0; Clear = 1'b0; StepReq = 1'b0;
`ifdef SEQ_MASK_EN
      Mask = 4'b0000;
`endif
      #1;
      chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);
      clk1(); clk1();
      Rst_n = 1'b1;
      clk1();

      // Free run, DIV=4, up: advances at edges 4,8,12,16; wrap only on the last.
      Run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         clk1(); clk1(); clk1();
         chk_all("fr_pre", (i == 0) ? 2'b00 : up_seq[i-1], 1'b0, 1'b0, 1'b0);
         clk1();
         chk_all("fr_adv", up_seq[i], 1'b1, (i == 3), 1'b0);
      end

      // Async reset right after a tick, checked before any further edge.
      clk1(); clk1(); clk1(); clk1();
      chk_all("fr_again", 2'b01, 1'b1, 1'b0, 1'b0);
      Rst_n = 1'b0;
      #1;
      chk_all("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
      Run = 1'b0;
      clk1();
      Rst_n = 1'b1;
      clk1();

      // Down step held 5 cycles: one advance 00->11 with wrap, ack drops one edge after release.
      Dir = 1'b1; StepReq = 1'b1;
      clk1();
      chk_all("step_dn", 2'b11, 1'b1, 1'b1, 1'b1);
      clk1(); clk1(); clk1(); clk1();
      chk_all("step_hold", 2'b11, 1'b0, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();
      chk_all("step_rel", 2'b11, 1'b0, 1'b0, 1'b0);

      // Reach 10, then Clear on the prescaler terminal count.
      StepReq = 1'b1;
      clk1();
      chk_all("step_to2", 2'b10, 1'b1, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();
      Dir = 1'b0; Run = 1'b1;
      clk1(); clk1(); clk1();
      Clear = 1'b1;
      clk1();
      chk_all("clr_tc", 2'b00, 1'b0, 1'b0, 1'b0);
      Clear = 1'b0;
      clk1(); clk1(); clk1();
      chk_all("clr_pre", 2'b00, 1'b0, 1'b0, 1'b0);
      clk1();
      chk_all("clr_post", 2'b01, 1'b1, 1'b0, 1'b0);

      // StepReq ignored under Run; dropping Run with StepReq high gives exactly one step.
      StepReq = 1'b1;
      clk1(); clk1();
      chk_all("run_ign", 2'b01, 1'b0, 1'b0, 1'b0);
      Run = 1'b0;
      clk1();
      chk_all("run_drop", 2'b10, 1'b1, 1'b0, 1'b1);
      clk1();
      chk_all("run_one", 2'b10, 1'b0, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();
      chk_all("run_rel", 2'b10, 1'b0, 1'b0, 1'b0);
      // Prescaler held at 2 while Run was low: two more edges to the next advance.
      Run = 1'b1;
      clk1();
      chk_all("hold_pre", 2'b10, 1'b0, 1'b0, 1'b0);
      clk1();
      chk_all("hold_adv", 2'b11, 1'b1, 1'b0, 1'b0);
      Run = 1'b0;
      clk1();

      // Reset mid-handshake: the still-high request must drop before it counts.
      StepReq = 1'b1;
      clk1();
      chk_all("hs_adv", 2'b00, 1'b1, 1'b1, 1'b1);
      Rst_n = 1'b0;
      #1;
      chk_all("hs_rst", 2'b00, 1'b0, 1'b0, 1'b0);
      Rst_n = 1'b1;
      clk1();
      chk_all("hs_blk", 2'b00, 1'b0, 1'b0, 1'b0);
      StepReq = 1'b0;
      clk1();
      StepReq = 1'b1;
      clk1();
      chk_all("hs_new", 2'b01, 1'b1, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();

      // Clear with a coincident request: not consumed, so it advances on the next edge.
      Clear = 1'b1; StepReq = 1'b1;
      clk1();
      chk_all("clr_req", 2'b00, 1'b0, 1'b0, 1'b0);
      Clear = 1'b0;
      clk1();
      chk_all("clr_req2", 2'b01, 1'b1, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();

`ifdef SEQ_MASK_EN
      Clear = 1'b1;
      clk1();
      Clear = 1'b0; Mask = 4'b0110; Dir = 1'b0;
      StepReq = 1'b1;
      clk1();
      chk_all("mask_a", 2'b11, 1'b1, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();
      StepReq = 1'b1;
      clk1();
      chk_all("mask_b", 2'b00, 1'b1, 1'b1, 1'b1);
      StepReq = 1'b0;
      clk1();
      Mask = 4'b1111;
      StepReq = 1'b1;
      clk1();
      chk_all("mask_all", 2'b00, 1'b0, 1'b0, 1'b1);
      StepReq = 1'b0;
      clk1();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
